aes_stream_ctrl: RTL and testbench

Upstream/downstream sequencer for the iterative AES core. It collects 32-bit words from a valid/ready input stream into a 128-bit block and holds a 256-bit key in a word-addressed register file. It pulses the core's load, tracks the core's busy, and captures the result. The result is returned as four 32-bit words on a valid/ready output stream, with a watchdog that flags a core that never finishes.

---
 rtl/aes_stream_ctrl.sv | 173 +++++++++++++++++
 tb/tb_aes_stream_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - stream sequencer around an iterative AES core
module aes_stream_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             key_we_i,
    input  logic [2:0]       key_addr_i,
    input  logic [31:0]      key_wdata_i,
    input  logic [1:0]       cfg_size_i,
    input  logic             cfg_dec_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [31:0]      s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [31:0]      m_data_o,
    output logic             core_load_o,
    output logic [255:0]     core_key_o,
    output logic [127:0]     core_data_o,
    output logic [1:0]       core_size_o,
    output logic             core_dec_o,
    input  logic             core_busy_i,
    input  logic [127:0]     core_data_i,
    output logic             err_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    // The counter is cleared in the load cycle; expiring when it holds
    // TIMEOUT-2 lands err_o exactly TIMEOUT cycles after the load pulse.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_LOAD,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         in_idx_q, in_idx_d;
    logic [1:0]         out_idx_q, out_idx_d;
    logic [127:0]       data_q, data_d;
    logic [255:0]       key_q, key_d;
    logic [1:0]         size_q, size_d;
    logic               dec_q, dec_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       res_q, res_d;
    logic               wd_expired;

    assign wd_expired  = (wd_q == WD_LAST);

    assign core_key_o  = key_q;
    assign core_data_o = data_q;
    assign core_size_o = size_q;
    assign core_dec_o  = dec_q;
    assign err_o       = err_q;
    assign blk_cnt_o   = cnt_q;
    assign m_data_o    = res_q[32*(2'd3 - out_idx_q) +: 32];

    // Next-state and datapath: collect, load, wait for core, drain result
    always_comb begin
        state_d     = state_q;
        in_idx_d    = in_idx_q;
        out_idx_d   = out_idx_q;
        data_d      = data_q;
        key_d       = key_q;
        size_d      = size_q;
        dec_d       = dec_q;
        wd_d        = wd_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        s_ready_o   = 1'b0;
        m_valid_o   = 1'b0;
        core_load_o = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                s_ready_o = 1'b1;
                // Key may only change between blocks, never mid-collection
                if (key_we_i && (in_idx_q == 2'd0)) begin
                    key_d[32*(3'd7 - key_addr_i) +: 32] = key_wdata_i;
                end
                if (s_valid_i) begin
                    data_d   = {data_q[95:0], s_data_i};
                    in_idx_d = in_idx_q + 2'd1;
                    if (in_idx_q == 2'd3) begin
                        size_d  = cfg_size_i;
                        dec_d   = cfg_dec_i;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                core_load_o = 1'b1;
                wd_d        = '0;
                state_d     = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                wd_d = wd_q + WD_W'(1);
                // Expiry is checked first so it beats a late busy rise
                if (wd_expired) begin
                    err_d    = 1'b1;
                    in_idx_d = 2'd0;
                    state_d  = ST_COLLECT;
                end else if (core_busy_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                wd_d = wd_q + WD_W'(1);
                if (wd_expired) begin
                    err_d    = 1'b1;
                    in_idx_d = 2'd0;
                    state_d  = ST_COLLECT;
                end else if (!core_busy_i) begin
                    res_d     = core_data_i;
                    cnt_d     = cnt_q + CNT_W'(1);
                    out_idx_d = 2'd0;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                m_valid_o = 1'b1;
                if (m_ready_i) begin
                    out_idx_d = out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= ST_COLLECT;
            in_idx_q  <= 2'd0;
            out_idx_q <= 2'd0;
            data_q    <= '0;
            key_q     <= '0;
            size_q    <= 2'd0;
            dec_q     <= 1'b0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            data_q    <= data_d;
            key_q     <= key_d;
            size_q    <= size_d;
            dec_q     <= dec_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - randomized self-checking bench for aes_stream_ctrl
module tb_aes_stream_ctrl;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 2;

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             key_we_i = 1'b0;
    logic [2:0]       key_addr_i = 3'd0;
    logic [31:0]      key_wdata_i = 32'd0;
    logic [1:0]       cfg_size_i = 2'd0;
    logic             cfg_dec_i = 1'b0;
    logic             s_valid_i = 1'b0;
    logic             s_ready_o;
    logic [31:0]      s_data_i = 32'd0;
    logic             m_valid_o;
    logic             m_ready_i = 1'b0;
    logic [31:0]      m_data_o;
    logic             core_load_o;
    logic [255:0]     core_key_o;
    logic [127:0]     core_data_o;
    logic [1:0]       core_size_o;
    logic             core_dec_o;
    logic             core_busy_i = 1'b0;
    logic [127:0]     core_data_i = 128'd0;
    logic             err_o;
    logic [CNT_W-1:0] blk_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] mkey = '0;
    int           mcnt = 0;

    bit           cm_stuck = 1'b0;
    int           cm_delay = 2;
    int           cm_len   = 4;
    bit           cm_act   = 1'b0;
    int           cm_wait  = 0;
    int           cm_run   = 0;
    logic [127:0] cm_res   = '0;
    int           cm_loads = 0;

    always #5 clk = ~clk;

    aes_stream_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_i(rst_i),
        .key_we_i(key_we_i), .key_addr_i(key_addr_i), .key_wdata_i(key_wdata_i),
        .cfg_size_i(cfg_size_i), .cfg_dec_i(cfg_dec_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .core_load_o(core_load_o), .core_key_o(core_key_o), .core_data_o(core_data_o),
        .core_size_o(core_size_o), .core_dec_o(core_dec_o),
        .core_busy_i(core_busy_i), .core_data_i(core_data_i),
        .err_o(err_o), .blk_cnt_o(blk_cnt_o)
    );

    // Stand-in cipher: real AES answer for the known vector, otherwise a keyed mix
    function automatic logic [127:0] cipher(input logic [255:0] k, input logic [127:0] d,
                                            input logic [1:0] sz, input logic dc);
        if (k[255:128] == FIPS_K && k[127:0] == '0 && sz == 2'd0) begin
            if (!dc && d == FIPS_P) return FIPS_C;
            if (dc && d == FIPS_C) return FIPS_P;
        end
        return d ^ k[255:128] ^ k[127:0] ^ {dc, sz, 125'd0};
    endfunction

    // Core model: busy rises after cm_delay, stays cm_len cycles, result on fall
    always @(posedge clk) begin
        if (core_load_o) begin
            cm_loads <= cm_loads + 1;
            if (!cm_stuck) begin
                cm_act  <= 1'b1;
                cm_wait <= cm_delay;
                cm_run  <= cm_len;
                cm_res  <= cipher(core_key_o, core_data_o, core_size_o, core_dec_o);
            end
        end else if (cm_act) begin
            if (!core_busy_i) begin
                if (cm_wait == 0) core_busy_i <= 1'b1;
                else cm_wait <= cm_wait - 1;
            end else if (cm_run <= 1) begin
                core_busy_i <= 1'b0;
                core_data_i <= cm_res;
                cm_act      <= 1'b0;
            end else begin
                cm_run <= cm_run - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_s_ready", s_ready_o, 1);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_load", core_load_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_blk_cnt", blk_cnt_o, 0);
        chk("rst_key", core_key_o, 0);
        chk("rst_core_data", core_data_o, 0);
        chk("rst_size", core_size_o, 0);
        chk("rst_dec", core_dec_o, 0);
        chk("rst_m_data", m_data_o, 0);
    endtask

    task automatic key_write(input logic [2:0] a, input logic [31:0] d, input bit accept);
        key_we_i = 1'b1; key_addr_i = a; key_wdata_i = d;
        @(negedge clk);
        key_we_i = 1'b0;
        if (accept) mkey[32*(7-int'(a)) +: 32] = d;
        chk("core_key", core_key_o, mkey);
    endtask

    task automatic send_word(input logic [31:0] w);
        int t;
        t = 0;
        s_valid_i = 1'b1; s_data_i = w;
        while (!s_ready_o && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) chk("s_ready_wait", s_ready_o, 1);
        @(negedge clk);
        s_valid_i = 1'b0; s_data_i = $urandom;
    endtask

    task automatic run_block(input logic [127:0] din, input logic [1:0] sz, input logic dc,
                             input logic [127:0] exp, input int stall_w, input int stall_n,
                             input bit kw_mid, input bit kw_run);
        int t;
        int n;
        int l0;
        logic [31:0] ew;
        l0 = cm_loads;
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (kw_mid && i == 2) key_write(3'($urandom_range(0, 7)), $urandom, 1'b0);
            if (i == 3) begin cfg_size_i = sz; cfg_dec_i = dc; end
            else begin cfg_size_i = 2'($urandom); cfg_dec_i = 1'($urandom); end
            send_word(din[32*(3-i) +: 32]);
        end
        cfg_size_i = ~sz; cfg_dec_i = ~dc;
        chk("load_pulse", core_load_o, 1);
        chk("s_ready_in_load", s_ready_o, 0);
        chk("core_data", core_data_o, din);
        chk("core_size", core_size_o, sz);
        chk("core_dec", core_dec_o, dc);
        if (kw_run) begin
            t = 0;
            while (!core_busy_i && t < 300) begin @(negedge clk); t++; end
            @(negedge clk);
            key_write(3'd0, $urandom, 1'b0);
        end
        for (int w = 0; w < 4; w++) begin
            t = 0;
            while (!m_valid_o && t < 300) begin @(negedge clk); t++; end
            if (t >= 300) chk("m_valid_wait", m_valid_o, 1);
            ew = exp[32*(3-w) +: 32];
            n = (w == stall_w) ? stall_n : $urandom_range(0, 2);
            repeat (n) begin
                chk("hold_data", m_data_o, ew);
                chk("hold_valid", m_valid_o, 1);
                @(negedge clk);
            end
            chk("m_data", m_data_o, ew);
            chk("drain_s_ready", s_ready_o, 0);
            m_ready_i = 1'b1;
            @(negedge clk);
            m_ready_i = 1'b0;
        end
        mcnt++;
        chk("m_valid_after", m_valid_o, 0);
        chk("s_ready_after", s_ready_o, 1);
        chk("blk_cnt", blk_cnt_o, mcnt % (1 << CNT_W));
        chk("load_count", cm_loads - l0, 1);
    endtask

    task automatic run_timeout(input logic [127:0] din, input bit stuck, input int delay);
        bit mv;
        logic err_before;
        mv = 1'b0;
        err_before = err_o;
        cm_stuck = stuck; cm_delay = delay; cm_len = 5;
        for (int i = 0; i < 4; i++) send_word(din[32*(3-i) +: 32]);
        chk("to_load", core_load_o, 1);
        for (int k = 1; k <= TIMEOUT + 20; k++) begin
            @(negedge clk);
            if (m_valid_o) mv = 1'b1;
            if (k == TIMEOUT - 1) begin
                chk("to_err_before", err_o, err_before);
                chk("to_s_ready_before", s_ready_o, 0);
            end
            if (k == TIMEOUT) begin
                chk("to_err", err_o, 1);
                chk("to_s_ready", s_ready_o, 1);
            end
        end
        chk("to_no_m_valid", mv, 0);
        chk("to_blk_cnt", blk_cnt_o, mcnt % (1 << CNT_W));
        cm_stuck = 1'b0; cm_delay = 2; cm_len = 4;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] din;
        logic [1:0]   sz;
        logic         dc;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check_reset();

        for (int a = 0; a < 4; a++) key_write(3'(a), FIPS_K[32*(3-a) +: 32], 1'b1);
        run_block(FIPS_P, 2'd0, 1'b0, FIPS_C, -1, 0, 1'b0, 1'b0);
        run_block(FIPS_C, 2'd0, 1'b1, FIPS_P, -1, 0, 1'b0, 1'b0);
        run_block(FIPS_P, 2'd0, 1'b0, FIPS_C, 2, 5, 1'b0, 1'b0);

        run_timeout({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
        run_block(FIPS_P, 2'd0, 1'b0, FIPS_C, -1, 0, 1'b0, 1'b0);
        run_timeout({$urandom, $urandom, $urandom, $urandom}, 1'b0, TIMEOUT - 3);

        cm_len = 6;
        run_block(FIPS_P, 2'd0, 1'b0, FIPS_C, -1, 0, 1'b0, 1'b1);
        cm_len = 4;

        send_word($urandom);
        send_word($urandom);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        mkey = '0;
        mcnt = 0;
        check_reset();

        for (int b = 0; b < 14; b++) begin
            if (b == 0 || $urandom_range(0, 2) == 0)
                for (int a = 0; a < 8; a++) key_write(3'(a), $urandom, 1'b1);
            din = {$urandom, $urandom, $urandom, $urandom};
            sz  = 2'($urandom_range(0, 2));
            dc  = 1'($urandom);
            cm_delay = $urandom_range(0, 6);
            cm_len   = $urandom_range(1, 10);
            run_block(din, sz, dc, cipher(mkey, din, sz, dc),
                      $urandom_range(0, 4), $urandom_range(1, 4), (b % 3) == 1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
